// File: rtl/imem_loader_pkg.sv
// Shared types and defaults for the boot-time instruction memory loader.
package imem_loader_pkg;

    localparam int BYTE_W = 8;
    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 16;
    localparam int TIMEOUT_CYC_DEF = 1024;
    localparam logic [BYTE_W-1:0] SYNC_BYTE_DEF = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_HI,
        ST_LO,
        ST_WR,
        ST_CHK,
        ST_DONE,
        ST_ERR
    } state_t;

endpackage

// File: rtl/imem_loader_timeout.sv
// Inter-byte idle watchdog: a down-counter reloaded on clear, expiring at terminal count.
module loader_timeout #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;

    // A clear in the same cycle (an accepted byte) always beats the expiry.
    assign expire = enable && !clear && (cnt_q == '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= LOAD_VAL;
        end else if (enable && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader for the 16x256 instruction memory; holds the CPU
// in reset until a frame with a good XOR checksum has been written.
//
// state | meaning
// IDLE  | waiting for sync, other bytes discarded
// LEN   | expecting word count (0 means 256)
// HI    | expecting high byte of next word
// LO    | expecting low byte of next word
// WR    | one-cycle memory write, input stalled
// CHK   | expecting checksum byte
// DONE  | good load, CPU released, waiting for sync
// ERR   | bad checksum or timeout, CPU held, waiting for sync
import imem_loader_pkg::*;

module imem_loader #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_error
);

    state_t state, state_nxt;

    logic [7:0]        len_q;
    logic [7:0]        hi_q;
    logic [7:0]        chk_q;
    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] last_idx;
    logic              accept;
    logic              timed;
    logic              tmo_clear;
    logic              tmo_expire;

    assign accept = in_valid && in_ready;
    assign timed = (state == ST_LEN) || (state == ST_HI) || (state == ST_LO) || (state == ST_CHK);
    assign tmo_clear = accept || !timed;
    // LEN=0 wraps to 255 here, which is exactly the last index of a 256-word load.
    assign last_idx = ADDR_W'(len_q - 8'd1);

    loader_timeout #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clock (clock),
        .reset (reset),
        .clear (tmo_clear),
        .enable(timed),
        .expire(tmo_expire)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (accept && (in_data == SYNC_BYTE)) state_nxt = ST_LEN;
            end
            ST_LEN: begin
                if (accept) state_nxt = ST_HI;
                else if (tmo_expire) state_nxt = ST_ERR;
            end
            ST_HI: begin
                if (accept) state_nxt = ST_LO;
                else if (tmo_expire) state_nxt = ST_ERR;
            end
            ST_LO: begin
                if (accept) state_nxt = ST_WR;
                else if (tmo_expire) state_nxt = ST_ERR;
            end
            ST_WR: begin
                state_nxt = (idx_q == last_idx) ? ST_CHK : ST_HI;
            end
            ST_CHK: begin
                if (accept) state_nxt = (in_data == chk_q) ? ST_DONE : ST_ERR;
                else if (tmo_expire) state_nxt = ST_ERR;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            in_ready   <= 1'b1;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_hold   <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
            len_q      <= '0;
            hi_q       <= '0;
            chk_q      <= '0;
            idx_q      <= '0;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt != ST_WR);
            imem_we  <= (state_nxt == ST_WR);
            cpu_hold <= (state_nxt != ST_DONE);

            if ((state_nxt == ST_DONE) && (state != ST_DONE)) load_done <= 1'b1;
            if ((state_nxt == ST_ERR) && (state != ST_ERR)) load_error <= 1'b1;

            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (state_nxt == ST_LEN) begin
                        load_done  <= 1'b0;
                        load_error <= 1'b0;
                        chk_q      <= '0;
                        idx_q      <= '0;
                    end
                end
                ST_LEN: begin
                    if (accept) len_q <= in_data;
                end
                ST_HI: begin
                    if (accept) begin
                        hi_q  <= in_data;
                        chk_q <= chk_q ^ in_data;
                    end
                end
                ST_LO: begin
                    if (accept) begin
                        chk_q      <= chk_q ^ in_data;
                        imem_addr  <= idx_q;
                        imem_wdata <= DATA_W'({hi_q, in_data});
                    end
                end
                ST_WR: begin
                    if (idx_q != last_idx) idx_q <= idx_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench: frame senders queue expected writes, a monitor checks them.
module tb_imem_loader;

    logic        clock;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [15:0] imem_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_error;

    typedef struct packed {
        logic [7:0]  a;
        logic [15:0] d;
    } wr_t;

    wr_t         exp_q[$];
    logic [15:0] fw[$];
    int          total = 0;
    int          bad = 0;

    imem_loader dut (
        .clock     (clock),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .load_error(load_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (reset) begin
            if (imem_we) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got addr %0h data %0h expected none", imem_addr, imem_wdata);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("write_addr", 32'(imem_addr), 32'(e.a));
                    chk("write_data", 32'(imem_wdata), 32'(e.d));
                end
            end
            chk("ready_only_outside_wr", 32'(in_ready), 32'(!imem_we));
        end
    end

    task automatic send_byte(input logic [7:0] b);
        logic r;
        int   n;
        @(negedge clock);
        in_data = b;
        in_valid = 1'b1;
        n = 0;
        r = in_ready;
        @(posedge clock);
        while (!r) begin
            n++;
            if (n > 8) begin
                total++;
                bad++;
                $display("FAIL send_byte_stall: got no ready for byte %0h expected ready within 8 cycles", b);
                break;
            end
            @(negedge clock);
            r = in_ready;
            @(posedge clock);
        end
    endtask

    task automatic idle();
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    // Sends LEN, the words in fw (queuing their expected writes) and CHK.
    task automatic send_body(input logic [7:0] len, input logic [7:0] chk_b);
        send_byte(len);
        for (int i = 0; i < fw.size(); i++) begin
            wr_t e;
            e.a = 8'(i);
            e.d = fw[i];
            exp_q.push_back(e);
            send_byte(fw[i][15:8]);
            send_byte(fw[i][7:0]);
        end
        send_byte(chk_b);
    endtask

    initial begin
        logic [7:0] x;
        reset = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        repeat (4) @(negedge clock);
        chk("rst_cpu_hold", 32'(cpu_hold), 1);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_imem_we", 32'(imem_we), 0);
        chk("rst_load_done", 32'(load_done), 0);
        chk("rst_load_error", 32'(load_error), 0);

        // good two-word frame
        fw = '{16'h1234, 16'hABCD};
        send_byte(8'hA5);
        send_body(8'h02, 8'h40);
        idle();
        chk("good_load_done", 32'(load_done), 1);
        chk("good_cpu_hold", 32'(cpu_hold), 0);
        chk("good_load_error", 32'(load_error), 0);
        chk("good_writes_drained", 32'(exp_q.size()), 0);

        // same frame, bad checksum
        send_byte(8'hA5);
        send_body(8'h02, 8'h41);
        idle();
        chk("bad_load_error", 32'(load_error), 1);
        chk("bad_load_done", 32'(load_done), 0);
        chk("bad_cpu_hold", 32'(cpu_hold), 1);
        chk("bad_writes_drained", 32'(exp_q.size()), 0);

        // recovery: error clears on sync
        send_byte(8'hA5);
        idle();
        chk("sync_clears_error", 32'(load_error), 0);
        chk("sync_cpu_hold", 32'(cpu_hold), 1);
        send_body(8'h02, 8'h40);
        idle();
        chk("recover_load_done", 32'(load_done), 1);
        chk("recover_cpu_hold", 32'(cpu_hold), 0);

        // garbage then LEN=0 (256 words)
        fw.delete();
        x = 8'h00;
        for (int i = 0; i < 256; i++) begin
            fw.push_back({8'(i), ~8'(i)});
            x = x ^ 8'(i) ^ ~8'(i);
        end
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        send_byte(8'hA5);
        send_body(8'h00, x);
        idle();
        chk("len0_load_done", 32'(load_done), 1);
        chk("len0_last_addr", 32'(imem_addr), 32'h00FF);
        chk("len0_last_data", 32'(imem_wdata), 32'hFF00);
        chk("len0_writes_drained", 32'(exp_q.size()), 0);

        // stall after HI byte: expires on the 1024th idle cycle
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h12);
        idle();
        repeat (1023) @(posedge clock);
        @(negedge clock);
        chk("tmo_not_yet", 32'(load_error), 0);
        @(posedge clock);
        @(negedge clock);
        chk("tmo_load_error", 32'(load_error), 1);
        chk("tmo_cpu_hold", 32'(cpu_hold), 1);
        chk("tmo_in_ready", 32'(in_ready), 1);

        // 1023-cycle stall then byte: byte wins
        fw = '{16'h1234};
        exp_q.push_back('{a: 8'h00, d: 16'h1234});
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h12);
        idle();
        repeat (1023) @(posedge clock);
        send_byte(8'h34);
        send_byte(8'h26);
        idle();
        chk("stall_no_error", 32'(load_error), 0);
        chk("stall_load_done", 32'(load_done), 1);

        // async reset while DONE
        #1 reset = 1'b0;
        #1;
        chk("rst_done_load_done", 32'(load_done), 0);
        chk("rst_done_cpu_hold", 32'(cpu_hold), 1);
        chk("rst_done_addr", 32'(imem_addr), 0);
        @(negedge clock);
        reset = 1'b1;

        // async reset mid-frame, right while word 1 is being written
        fw = '{16'h1122, 16'h3344, 16'h5566};
        exp_q.push_back('{a: 8'h00, d: 16'h1122});
        exp_q.push_back('{a: 8'h01, d: 16'h3344});
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        @(negedge clock);
        in_valid = 1'b0;
        #1 reset = 1'b0;
        #1;
        chk("mid_rst_imem_we", 32'(imem_we), 0);
        chk("mid_rst_in_ready", 32'(in_ready), 1);
        chk("mid_rst_addr", 32'(imem_addr), 0);
        chk("mid_rst_wdata", 32'(imem_wdata), 0);
        chk("mid_rst_cpu_hold", 32'(cpu_hold), 1);
        chk("mid_rst_load_error", 32'(load_error), 0);
        chk("mid_rst_writes_drained", 32'(exp_q.size()), 0);
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        chk("post_rst_no_write", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
